// File: rtl/moore_arb_pkg.sv
// Shared definitions for the Moore step arbiter: state encoding, default sizes
// and the index-width helper. Optional feature macro: MOORE_ARB_FAIR_EN.
package moore_arb_pkg;

  localparam int NREQ_DEF  = 2;
  localparam int CNT_W_DEF = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_RUN    = RUN,
    ST_SETTLE = SETTLE,
    ST_DONE   = DONE
  } state_t;

  // Index width for n requesters; never below one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/moore_arb_pick.sv
// Combinational winner picker. MOORE_ARB_FAIR_EN selects round-robin starting
// at rr_ptr; otherwise the lowest set request index wins.
module moore_arb_pick
  import moore_arb_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  localparam int IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
`ifdef MOORE_ARB_FAIR_EN
  input  logic [IDX_W-1:0] rr_ptr,
`endif
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

`ifdef MOORE_ARB_FAIR_EN
  logic [IDX_W:0] idx;

  // Scan from the farthest offset down so the nearest set request at or after
  // rr_ptr is the last one written.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (idx >= (IDX_W + 1)'(NREQ)) idx = idx - (IDX_W + 1)'(NREQ);
      if (req[idx[IDX_W-1:0]]) begin
        winner = idx[IDX_W-1:0];
        valid  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        winner = IDX_W'(k);
        valid  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/moore_step_arbiter.sv
// Shares one 2-bit Moore toggle-counter datapath between NREQ requesters and
// counts detect-state hits per job. Optional feature macro: MOORE_ARB_FAIR_EN.
module moore_step_arbiter
  import moore_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] len_flat,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [CNT_W-1:0]      hits,
  output logic                  busy,
  output logic                  x_out,
  input  logic                  y_in
);

  localparam int IDX_W = clog2(NREQ);

  state_t           state, next_state;
  logic [CNT_W-1:0] remaining;
  logic             x_q;
  logic [CNT_W-1:0] len_arr [NREQ];
  logic [IDX_W-1:0] pick_win;
  logic             pick_valid;
  logic             take;

  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign len_arr[i] = len_flat[i*CNT_W +: CNT_W];
  end

`ifdef MOORE_ARB_FAIR_EN
  logic [IDX_W-1:0] rr_ptr;
`endif

  moore_arb_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
`ifdef MOORE_ARB_FAIR_EN
    .rr_ptr (rr_ptr),
`endif
    .winner (pick_win),
    .valid  (pick_valid)
  );

  always_comb begin
    next_state = state;
    take       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          take       = 1'b1;
          next_state = (len_arr[pick_win] != '0) ? ST_RUN : ST_SETTLE;
        end
      end
      ST_RUN:    if (remaining == CNT_W'(1)) next_state = ST_SETTLE;
      ST_SETTLE: next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant     <= '0;
      done      <= '0;
      hits      <= '0;
      busy      <= 1'b0;
      x_out     <= 1'b0;
      x_q       <= 1'b0;
      remaining <= '0;
`ifdef MOORE_ARB_FAIR_EN
      rr_ptr    <= '0;
`endif
    end else begin
      x_q   <= x_out;
      x_out <= (next_state == ST_RUN);
      busy  <= (next_state != ST_IDLE);
      done  <= (next_state == ST_DONE) ? grant : '0;

      if (take) begin
        grant     <= {{(NREQ-1){1'b0}}, 1'b1} << pick_win;
        remaining <= len_arr[pick_win];
        hits      <= '0;
`ifdef MOORE_ARB_FAIR_EN
        rr_ptr    <= (pick_win == IDX_W'(NREQ - 1)) ? '0 : pick_win + 1'b1;
`endif
      end else begin
        if (state == ST_DONE) grant <= '0;
        if (state == ST_RUN) remaining <= remaining - 1'b1;
        // A hit needs a step issued last cycle; a stale 11 left by an earlier job does not count.
        if ((state == ST_RUN || state == ST_SETTLE) && x_q && y_in && hits != '1)
          hits <= hits + 1'b1;
      end
    end
  end

endmodule
